// File: rtl/gate_check_sequencer.sv
`timescale 1ns/1ps
// gate_check_sequencer
//   Self-checking stimulus controller for the six-gate basic-logic DUT.
//   Vectors come from an 18-bit Fibonacci LFSR and are driven as {dut_b,dut_a}.
//   Each vector is held for SETTLE_CYCLES cycles, then dut_o is compared
//   against a golden model of the gates. The mismatch count and the first
//   failing vector are reported.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        run request / run termination
//   dut_a, dut_b        registered DUT inputs (taken from the LFSR)
//   dut_o               DUT outputs
//   busy, done, pass    run status
//   aborted             last run was terminated by abort
//   mismatch_cnt        saturating count of mismatching vectors
//   first_fail_*        index, observed and expected value of the first mismatch
module gate_check_sequencer #(
    parameter int unsigned NUM_VEC       = 256,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [17:0] SEED          = 18'h00001,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [15:0]      dut_a,
    output logic [1:0]       dut_b,
    input  logic [5:0]       dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [5:0]       first_fail_obs,
    output logic [5:0]       first_fail_exp
);
    // The vector index must reach NUM_VEC-1 even when CNT_W is narrow;
    // first_fail_idx reports its low CNT_W bits.
    localparam int unsigned IDX_W    = (CNT_W > $clog2(NUM_VEC + 1)) ? CNT_W : $clog2(NUM_VEC + 1);
    localparam int unsigned SC_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [17:0] SEED_EFF = (SEED == 18'h0) ? 18'h00001 : SEED;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [17:0]       lfsr_q, lfsr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ffidx_q, ffidx_d;
    logic [5:0]        ffobs_q, ffobs_d;
    logic [5:0]        ffexp_q, ffexp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              aborted_q, aborted_d;

    logic [5:0]        exp_v;
    logic              mism;
    logic [CNT_W-1:0]  cnt_inc;

    assign dut_a          = lfsr_q[15:0];
    assign dut_b          = lfsr_q[17:16];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign aborted        = aborted_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffidx_q;
    assign first_fail_obs = ffobs_q;
    assign first_fail_exp = ffexp_q;

    // Golden model of the gate DUT, from the registered vector
    assign exp_v[0] = ~lfsr_q[17];
    assign exp_v[1] = ~(lfsr_q[2] | lfsr_q[3] | lfsr_q[4] | lfsr_q[5]);
    assign exp_v[2] = lfsr_q[6] & lfsr_q[7] & lfsr_q[8] & lfsr_q[9];
    assign exp_v[3] = ~(lfsr_q[10] & lfsr_q[11] & lfsr_q[12] & lfsr_q[13]);
    assign exp_v[4] = lfsr_q[14] | lfsr_q[15] | lfsr_q[0] | lfsr_q[1];
    assign exp_v[5] = lfsr_q[16];

    assign mism    = (dut_o != exp_v);
    assign cnt_inc = (mism && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        idx_d     = idx_q;
        sc_d      = sc_q;
        cnt_d     = cnt_q;
        ffidx_d   = ffidx_q;
        ffobs_d   = ffobs_q;
        ffexp_d   = ffexp_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    lfsr_d    = SEED_EFF;
                    idx_d     = '0;
                    sc_d      = SC_W'(SETTLE_CYCLES - 1);
                    cnt_d     = '0;
                    ffidx_d   = '0;
                    ffobs_d   = '0;
                    ffexp_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            SETTLE, SAMPLE: begin
                if (abort) begin
                    // Any compare due this edge is dropped; counters freeze.
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (state_q == SETTLE) begin
                    if (sc_q == '0) state_d = SAMPLE;
                    else            sc_d    = sc_q - SC_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    // cnt_q==0 identifies the first mismatch; it saturates, never wraps
                    if (mism && (cnt_q == '0)) begin
                        ffidx_d = idx_q[CNT_W-1:0];
                        ffobs_d = dut_o;
                        ffexp_d = exp_v;
                    end
                    if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (cnt_inc == '0);
                    end else begin
                        state_d = SETTLE;
                        lfsr_d  = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
                        idx_d   = idx_q + IDX_W'(1);
                        sc_d    = SC_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            idx_q     <= '0;
            sc_q      <= '0;
            cnt_q     <= '0;
            ffidx_q   <= '0;
            ffobs_q   <= '0;
            ffexp_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            idx_q     <= idx_d;
            sc_q      <= sc_d;
            cnt_q     <= cnt_d;
            ffidx_q   <= ffidx_d;
            ffobs_q   <= ffobs_d;
            ffexp_q   <= ffexp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
        end
    end
endmodule

// File: tb/tb_gate_check_sequencer.sv
`timescale 1ns/1ps
module tb_gate_check_sequencer;
    localparam int M_NV = 256;
    localparam int M_S  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, start2;
    logic [5:0] fmask;
    bit cmp_en = 1'b0;
    int n_chk = 0, n_fail = 0;

    function automatic logic [5:0] gold(input logic [17:0] v);
        logic [15:0] a;
        logic [1:0]  b;
        a = v[15:0];
        b = v[17:16];
        return {b[0], |{a[15:14], a[1:0]}, ~&a[13:10], &a[9:6], ~|a[5:2], ~b[1]};
    endfunction

    function automatic logic [17:0] lfsr_step(input logic [17:0] v);
        return {v[16:0], v[17] ^ v[10]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // ---------------- main DUT (default parameters) ----------------
    logic [15:0] a0;  logic [1:0] b0;  logic [5:0] o0;
    logic busy0, done0, pass0, abt0;
    logic [15:0] cnt0, fidx0;  logic [5:0] fobs0, fexp0;
    assign o0 = gold({b0, a0}) ^ fmask;

    gate_check_sequencer #(.NUM_VEC(M_NV), .SETTLE_CYCLES(M_S), .SEED(18'h00001), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(a0), .dut_b(b0), .dut_o(o0),
        .busy(busy0), .done(done0), .pass(pass0), .aborted(abt0),
        .mismatch_cnt(cnt0), .first_fail_idx(fidx0),
        .first_fail_obs(fobs0), .first_fail_exp(fexp0));

    // ---------------- directed instances ----------------
    logic [15:0] a1, a2, a3;  logic [1:0] b1, b2, b3;  logic [5:0] o1, o2, o3;
    logic busy1, done1, pass1, abt1, busy2, done2, pass2, abt2, busy3, done3, pass3, abt3;
    logic [15:0] cnt1, fidx1, cnt2, fidx2;  logic [1:0] cnt3, fidx3;
    logic [5:0] fobs1, fexp1, fobs2, fexp2, fobs3, fexp3;
    assign o1 = gold({b1, a1});
    assign o2 = gold({b2, a2}) ^ 6'h04;
    assign o3 = ~gold({b3, a3});

    gate_check_sequencer #(.NUM_VEC(3), .SETTLE_CYCLES(1), .SEED(18'h0), .CNT_W(16)) u_sm (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .dut_a(a1), .dut_b(b1), .dut_o(o1),
        .busy(busy1), .done(done1), .pass(pass1), .aborted(abt1),
        .mismatch_cnt(cnt1), .first_fail_idx(fidx1),
        .first_fail_obs(fobs1), .first_fail_exp(fexp1));

    gate_check_sequencer #(.NUM_VEC(8), .SETTLE_CYCLES(4), .SEED(18'h00001), .CNT_W(16)) u_f8 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .dut_a(a2), .dut_b(b2), .dut_o(o2),
        .busy(busy2), .done(done2), .pass(pass2), .aborted(abt2),
        .mismatch_cnt(cnt2), .first_fail_idx(fidx2),
        .first_fail_obs(fobs2), .first_fail_exp(fexp2));

    gate_check_sequencer #(.NUM_VEC(6), .SETTLE_CYCLES(4), .SEED(18'h00001), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .dut_a(a3), .dut_b(b3), .dut_o(o3),
        .busy(busy3), .done(done3), .pass(pass3), .aborted(abt3),
        .mismatch_cnt(cnt3), .first_fail_idx(fidx3),
        .first_fail_obs(fobs3), .first_fail_exp(fexp3));

    // ---------------- behavioural model of the main DUT ----------------
    // A run is a time count t since the start edge; every (M_S+1)-th edge
    // samples vector k, which is the seed advanced k times.
    logic        m_run = 0, m_done = 0, m_pass = 0, m_abt = 0;
    int          m_t = 0, m_k = 0;
    logic [17:0] m_vec = 0;
    logic [15:0] m_cnt = 0, m_fidx = 0;
    logic [5:0]  m_fobs = 0, m_fexp = 0;

    always @(posedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pass = 0; m_abt = 0; m_vec = 0;
            m_cnt = 0; m_fidx = 0; m_fobs = 0; m_fexp = 0; m_t = 0; m_k = 0;
        end else if (m_run && abort) begin
            m_run = 0; m_done = 1; m_abt = 1; m_pass = 0;
        end else if (!m_run && start) begin
            m_run = 1; m_done = 0; m_pass = 0; m_abt = 0; m_t = 0; m_k = 0;
            m_vec = 18'h00001; m_cnt = 0; m_fidx = 0; m_fobs = 0; m_fexp = 0;
        end else if (m_run) begin
            m_t++;
            if (m_t % (M_S + 1) == 0) begin
                e = gold(m_vec);
                if (o0 !== e) begin
                    if (m_cnt == 0) begin m_fidx = 16'(m_k); m_fobs = o0; m_fexp = e; end
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                if (m_k == M_NV - 1) begin
                    m_run = 0; m_done = 1; m_pass = (m_cnt == 0);
                end else begin
                    m_k++;
                    m_vec = lfsr_step(m_vec);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {busy0, done0, pass0, abt0, b0, a0, cnt0, fidx0, fobs0, fexp0},
                {m_run, m_done, m_pass, m_abt, m_vec, m_cnt, m_fidx, m_fobs, m_fexp});
    end

    // ---------------- stimulus ----------------
    initial begin
        int e;
        rst_n = 0; start = 0; abort = 0; start2 = 0; fmask = 0;
        chk("gold_v0", gold(18'h00001), 6'h1B);
        chk("lfsr_s1", lfsr_step(18'h00001), 18'h00002);
        chk("lfsr_s2", lfsr_step(lfsr_step(18'h00001)), 18'h00004);
        chk("gold_f2", gold(18'h00001) ^ 6'h04, 6'h1F);

        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("reset", {busy0, done0, pass0, abt0, b0, a0, cnt0, fidx0, fobs0, fexp0}, 0);
        chk("reset_sat", {busy3, done3, pass3, abt3, b3, a3, cnt3, fidx3, fobs3, fexp3}, 0);
        rst_n = 1;

        // full clean run
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        chk("v0_a", a0, 16'h0001);
        chk("v0_b", b0, 2'd0);
        chk("v0_busy", busy0, 1'b1);
        e = 0;
        while (!done0 && e < 2000) begin @(posedge clk); #1; e++; end
        chk("done_edge", e, 1280);
        chk("end_stat", {pass0, busy0, cnt0}, {1'b1, 1'b0, 16'd0});

        // abort during run
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        repeat (10) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        chk("abort_stat", {done0, abt0, busy0, pass0}, 4'b1100);
        chk("abort_vec", a0, 16'h0004);

        // reset mid-run, then restart
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        repeat (37) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("midrst", {busy0, done0, pass0, abt0, b0, a0, cnt0, fidx0, fobs0, fexp0}, 0);
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        chk("restart_a", a0, 16'h0001);

        // directed small-parameter instances
        @(negedge clk) start2 = 1;
        @(posedge clk); #1 start2 = 0;
        chk("sm_v0", {b1, a1}, 18'h00001);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 2)  chk("sm_v1", {b1, a1}, 18'h00002);
            if (k == 4)  chk("sm_v2", {b1, a1}, 18'h00004);
            if (k == 5)  chk("sm_early", done1, 1'b0);
            if (k == 6)  chk("sm_done", {done1, pass1, busy1, cnt1}, {3'b110, 16'd0});
            if (k == 11) start2 = 1;
            if (k == 12) start2 = 0;
            if (k == 13) chk("sat_ignore", {busy3, done3}, 2'b10);
            if (k == 29) chk("sat_early", done3, 1'b0);
            if (k == 30) chk("sat_done", {done3, pass3, cnt3, fidx3}, {2'b10, 2'd3, 2'd0});
            if (k == 39) chk("f8_early", done2, 1'b0);
            if (k == 40) begin
                chk("f8_stat", {done2, pass2, abt2, cnt2}, {3'b100, 16'd8});
                chk("f8_first", {fidx2, fobs2, fexp2}, {16'd0, 6'h1F, 6'h1B});
            end
        end

        // randomized start/abort/reset/fault traffic
        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 149) == 0);
            abort = ($urandom_range(0, 2499) == 0);
            rst_n = ($urandom_range(0, 3999) != 0);
            fmask = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h00;
        end
        @(negedge clk);
        start = 0; abort = 0; rst_n = 1; fmask = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
